// File: rtl/sonic_ranger.sv
// sonic_ranger: drives an HC-SR04-style ultrasonic sensor from the system clock.
// Emits a periodic trigger pulse, times the returning echo with a microsecond
// tick, and converts the echo width to whole centimetres using a counter
// chain (no divider). The distance bus only changes on the valid strobe.
module sonic_ranger #(
  parameter int CLK_PER_US = 100,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       echo,
  output logic       trig,
  output logic [7:0] distance,
  output logic       valid,
  output logic       timeout
);

  // Counter widths; guarded so degenerate parameter values still give >= 1 bit.
  localparam int PRESC_W     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int PERIOD_W    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int US_MAX      = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int US_W        = $clog2(US_MAX + 1);
  localparam int SUB_W       = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int SYNC_STAGES = 2;

  localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(CLK_PER_US - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_US - 1);
  localparam logic [US_W-1:0]     TRIG_LAST   = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]     TMO_LAST    = US_W'(TIMEOUT_US - 1);
  localparam logic [SUB_W-1:0]    SUB_LAST    = SUB_W'(US_PER_CM - 1);

  typedef enum logic [2:0] {
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_DONE,
    ST_HOLD
  } state_t;

  state_t               state_reg;
  logic [PRESC_W-1:0]   presc_reg;
  logic                 tick_reg;
  logic [PERIOD_W-1:0]  period_reg;
  logic [US_W-1:0]      us_reg;
  logic [SUB_W-1:0]     sub_reg;
  logic [7:0]           cm_reg;
  logic                 hit_timeout_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                 echo_prev_reg;

  logic echo_s;
  logic echo_rise;
  logic echo_fall;
  logic period_wrap;

  // Synchronised echo and its single-cycle edge indications.
  assign echo_s    = sync_reg[SYNC_STAGES-1];
  assign echo_rise = echo_s & ~echo_prev_reg;
  assign echo_fall = ~echo_s & echo_prev_reg;

  // The last microsecond of the measurement period; aborts and restarts the cycle.
  assign period_wrap = tick_reg && (period_reg == PERIOD_LAST);

  // Two-flop synchroniser for the asynchronous echo pin, plus an edge-detect flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg      <= '0;
      echo_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], echo};
      echo_prev_reg <= echo_s;
    end
  end

  // Free-running prescaler producing a registered one-cycle microsecond tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= (presc_reg == PRESC_LAST);
      if (presc_reg == PRESC_LAST) begin
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  // Trigger-to-trigger period counter in microseconds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_reg <= '0;
    end else if (tick_reg) begin
      if (period_wrap) begin
        period_reg <= '0;
      end else begin
        period_reg <= period_reg + 1'b1;
      end
    end
  end

  // Measurement FSM with the us/cm counter chain and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_TRIG;
      trig            <= 1'b0;
      distance        <= 8'd255;
      valid           <= 1'b0;
      timeout         <= 1'b0;
      us_reg          <= '0;
      sub_reg         <= '0;
      cm_reg          <= '0;
      hit_timeout_reg <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (period_wrap && (state_reg != ST_DONE)) begin
        // New period: drop whatever was in progress and fire the trigger now,
        // so consecutive trigger rising edges are exactly one period apart.
        state_reg <= ST_TRIG;
        trig      <= 1'b1;
        us_reg    <= '0;
      end else begin
        case (state_reg)
          ST_TRIG: begin
            trig <= 1'b1;
            if (tick_reg) begin
              if (us_reg == TRIG_LAST) begin
                trig      <= 1'b0;
                us_reg    <= '0;
                state_reg <= ST_WAIT_RISE;
              end else begin
                us_reg <= us_reg + 1'b1;
              end
            end
          end

          ST_WAIT_RISE: begin
            // Only a true rising edge starts a measurement; an echo that is
            // already high here is ignored until it drops and rises again.
            if (echo_rise) begin
              us_reg    <= '0;
              sub_reg   <= '0;
              cm_reg    <= '0;
              state_reg <= ST_MEASURE;
            end else if (tick_reg) begin
              us_reg <= us_reg + 1'b1;
              if (us_reg == TMO_LAST) begin
                hit_timeout_reg <= 1'b1;
                state_reg       <= ST_DONE;
              end
            end
          end

          ST_MEASURE: begin
            // The tick on the falling-edge cycle still counts, so an echo of
            // N us accumulates exactly N ticks between the two edge decisions.
            if (tick_reg) begin
              us_reg <= us_reg + 1'b1;
              if (sub_reg == SUB_LAST) begin
                sub_reg <= '0;
                if (cm_reg != 8'd255) begin
                  cm_reg <= cm_reg + 8'd1;
                end
              end else begin
                sub_reg <= sub_reg + 1'b1;
              end
            end
            // Falling edge has priority over a coincident timeout.
            if (echo_fall) begin
              hit_timeout_reg <= 1'b0;
              state_reg       <= ST_DONE;
            end else if (tick_reg && (us_reg == TMO_LAST)) begin
              hit_timeout_reg <= 1'b1;
              state_reg       <= ST_DONE;
            end
          end

          ST_DONE: begin
            valid    <= 1'b1;
            timeout  <= hit_timeout_reg;
            distance <= hit_timeout_reg ? 8'd255 : cm_reg;
            us_reg   <= '0;
            // A wrap landing on DONE is honoured one cycle later.
            state_reg <= period_wrap ? ST_TRIG : ST_HOLD;
          end

          ST_HOLD: begin
            state_reg <= ST_HOLD;
          end

          default: begin
            state_reg <= ST_TRIG;
          end
        endcase
      end
    end
  end

endmodule
